// File: rtl/synchronous_fsm_pkg.sv
// State codes for the 12-state Gray-labelled sequencer.
// Each state label N is encoded as the Gray code N ^ (N >> 1).
package synchronous_fsm_pkg;

    typedef enum logic [3:0] {
        S0  = 4'b0000,
        S1  = 4'b0001,
        S2  = 4'b0011,
        S3  = 4'b0010,
        S4  = 4'b0110,
        S5  = 4'b0111,
        S6  = 4'b0101,
        S7  = 4'b0100,
        S8  = 4'b1100,
        S9  = 4'b1101,
        S10 = 4'b1111,
        S11 = 4'b1110,
        S12 = 4'b1010,
        S13 = 4'b1011,
        S14 = 4'b1001,
        S15 = 4'b1000
    } state_t;

    localparam state_t RESET_STATE = S2;
    localparam state_t Z_STATE     = S7;

endpackage

// File: rtl/synchronous_fsm_jam_dff.sv
// D flip-flop with asynchronous clear and preset.
// Clear wins over preset, although the top never asserts both together.
module jam_dff (
    input  logic clk,
    input  logic pre,
    input  logic clr,
    input  logic d,
    output logic q
);

    // State bit: async clear/preset, otherwise capture d on the rising edge
    always_ff @(posedge clk or posedge pre or posedge clr) begin
        if (clr) begin
            q <= 1'b0;
        end else if (pre) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/synchronous_fsm.sv
// 4-bit Moore sequencer cycling 2,7,13,6,12,14,4,3,8,1,10,5 (Gray-coded).
// Reset and jam load act asynchronously through each bit's preset/clear.
module synchronous_fsm
    import synchronous_fsm_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic JAM_A,
    input  logic JAM_B,
    input  logic JAM_C,
    input  logic JAM_D,
    input  logic JAM_Enable,
    output logic Clk_Q,
    output logic Qa,
    output logic Qb,
    output logic Qc,
    output logic Qd,
    output logic Z
);

    localparam logic [3:0] RESET_CODE = RESET_STATE;

    logic [3:0] q;
    logic [3:0] jam;
    logic [3:0] next_code;
    state_t     cur_state;
    state_t     next_state;

    assign jam = {JAM_D, JAM_C, JAM_B, JAM_A};

    // Reset has priority over jam, so each bit's preset and clear are mutually exclusive
    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic pre;
        logic clr;
        if (RESET_CODE[i]) begin : g_reset_one
            assign pre = Reset | (JAM_Enable & jam[i]);
            assign clr = ~Reset & JAM_Enable & ~jam[i];
        end else begin : g_reset_zero
            assign pre = ~Reset & JAM_Enable & jam[i];
            assign clr = Reset | (JAM_Enable & ~jam[i]);
        end
        jam_dff u_dff (
            .clk (Clk),
            .pre (pre),
            .clr (clr),
            .d   (next_code[i]),
            .q   (q[i])
        );
    end

    // Next-state decode; unused codes fall back into the main loop in one clock
    always_comb begin
        cur_state  = state_t'(q);
        next_state = RESET_STATE;
        case (cur_state)
            S2:      next_state = S7;
            S7:      next_state = S13;
            S13:     next_state = S6;
            S6:      next_state = S12;
            S12:     next_state = S14;
            S14:     next_state = S4;
            S4:      next_state = S3;
            S3:      next_state = S8;
            S8:      next_state = S1;
            S1:      next_state = S10;
            S10:     next_state = S5;
            S5:      next_state = S2;
            S9:      next_state = S4;
            S11:     next_state = RESET_STATE;
            S0:      next_state = RESET_STATE;
            S15:     next_state = RESET_STATE;
            default: next_state = RESET_STATE;
        endcase
        next_code = next_state;
    end

    assign Z     = (q == Z_STATE);
    assign Clk_Q = Clk;
    assign Qa    = q[0];
    assign Qb    = q[1];
    assign Qc    = q[2];
    assign Qd    = q[3];

endmodule

// File: tb/tb_synchronous_fsm.sv
// Self-checking bench for synchronous_fsm: directed scenarios plus random
// clock/jam/reset stimulus against a label-sequence reference model.
module tb_synchronous_fsm;

    logic Clk = 1'b0;
    logic Reset;
    logic JAM_A, JAM_B, JAM_C, JAM_D, JAM_Enable;
    logic Clk_Q, Qa, Qb, Qc, Qd, Z;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] model_q;

    synchronous_fsm dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .JAM_A      (JAM_A),
        .JAM_B      (JAM_B),
        .JAM_C      (JAM_C),
        .JAM_D      (JAM_D),
        .JAM_Enable (JAM_Enable),
        .Clk_Q      (Clk_Q),
        .Qa         (Qa),
        .Qb         (Qb),
        .Qc         (Qc),
        .Qd         (Qd),
        .Z          (Z)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] gray(input int n);
        return 4'(n ^ (n >> 1));
    endfunction

    // Reference: walk the label sequence; codes outside it recover per the label rules
    function automatic logic [3:0] model_next(input logic [3:0] c);
        int seq [12] = '{2, 7, 13, 6, 12, 14, 4, 3, 8, 1, 10, 5};
        for (int i = 0; i < 12; i++) begin
            if (gray(seq[i]) == c) return gray(seq[(i + 1) % 12]);
        end
        if (c == gray(9)) return gray(4);
        return gray(2);
    endfunction

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic check_state(input string tag);
        check_val(tag, {Qd, Qc, Qb, Qa}, model_q);
        check_val({tag, "_z"}, {3'b000, Z}, {3'b000, (model_q == gray(7))});
    endtask

    task automatic set_jam(input logic [3:0] c);
        {JAM_D, JAM_C, JAM_B, JAM_A} = c;
    endtask

    // Advance one rising edge and sample 1 ns later
    task automatic step(input string tag);
        @(posedge Clk);
        #1;
        model_q = model_next(model_q);
        check_state(tag);
    endtask

    // Jam pulse of 7 ns placed between two rising edges
    task automatic jam_pulse(input logic [3:0] c, input string tag);
        set_jam(c);
        JAM_Enable = 1'b1;
        #1;
        model_q = c;
        check_state({tag, "_async"});
        #6;
        JAM_Enable = 1'b0;
        #1;
        check_state({tag, "_held"});
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        int sel;
        Reset = 1'b1;
        JAM_Enable = 1'b0;
        set_jam(4'b0000);
        model_q = gray(2);
        #2;
        check_state("reset");
        @(posedge Clk);
        #1;
        check_state("reset_over_edge");
        check_val("clk_q_high", {3'b000, Clk_Q}, 4'b0001);
        Reset = 1'b0;
        #1;
        check_state("reset_release");

        for (int i = 0; i < 12; i++) step("seq");

        @(posedge Clk);
        #1;
        model_q = model_next(model_q);
        jam_pulse(4'b0011, "jam_0011");
        step("after_jam_0011");

        jam_pulse(4'b1101, "jam_1101");
        step("illegal_9");
        step("illegal_9_next");
        jam_pulse(4'b1110, "jam_1110");
        step("illegal_11");
        jam_pulse(4'b0000, "jam_0000");
        step("illegal_0");
        jam_pulse(4'b1000, "jam_1000");
        step("illegal_15");

        set_jam(4'b1010);
        JAM_Enable = 1'b1;
        model_q = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check_state("jam_hold");
        end
        JAM_Enable = 1'b0;
        step("jam_hold_release");

        set_jam(4'b1111);
        JAM_Enable = 1'b1;
        #1;
        model_q = 4'b1111;
        check_state("jam_1111");
        Reset = 1'b1;
        #1;
        model_q = gray(2);
        check_state("reset_over_jam");
        Reset = 1'b0;
        #1;
        model_q = 4'b1111;
        check_state("jam_after_reset");
        JAM_Enable = 1'b0;
        step("after_1111");

        @(negedge Clk);
        #1;
        check_val("clk_q_low", {3'b000, Clk_Q}, 4'b0000);
        @(posedge Clk);
        #1;
        model_q = model_next(model_q);
        check_state("realign");

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 15) begin
                step("rnd_step");
            end else if (sel < 18) begin
                a = 4'($urandom);
                b = 4'($urandom);
                set_jam(a);
                JAM_Enable = 1'b1;
                #1;
                model_q = a;
                check_state("rnd_jam_a");
                set_jam(b);
                #1;
                model_q = b;
                check_state("rnd_jam_b");
                JAM_Enable = 1'b0;
                step("rnd_after_jam");
            end else begin
                Reset = 1'b1;
                #1;
                model_q = gray(2);
                check_state("rnd_reset");
                Reset = 1'b0;
                step("rnd_after_reset");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
